// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, latches IF/ID, handles stall, redirect flush and halt.
// Optional FETCH_ALIGN_CHECK_EN forces even redirect targets and flags odd ones in misalign.
module fetch_unit #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned PC_STEP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  pc_out,
  input  logic [15:0] inst_in,
  input  logic        stall,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  input  logic        halt,
  output logic [15:0] ifid_inst,
  output logic [7:0]  ifid_pc,
  output logic        ifid_valid,
  output logic        halted,
  output logic [15:0] fetch_count,
  output logic        misalign
);

  localparam logic [7:0] Step = 8'(PC_STEP);

  typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ifid_inst_q, ifid_inst_d;
  logic [7:0]  ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [7:0]  target_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign target_pc = {redirect_pc[7:1], 1'b0};

  // Sticky: only a taken (non-halted) redirect to an odd address can set it.
  always_comb begin
    misalign_d = misalign_q;
    if (state_q != StHalt && !halt && redirect && redirect_pc[0]) begin
      misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign = misalign_q;
`else
  assign target_pc = redirect_pc;
  assign misalign  = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_inst_d   = ifid_inst_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;
    unique case (state_q)
      StRun, StFlush: begin
        if (halt) begin
          ifid_valid_d = 1'b0;
          state_d      = StHalt;
        end else if (redirect) begin
          pc_d         = target_pc;
          ifid_valid_d = 1'b0;
          state_d      = StFlush;
        end else begin
          state_d = StRun;
          if (!stall) begin
            pc_d          = pc_q + Step;
            ifid_inst_d   = inst_in;
            ifid_pc_d     = pc_q;
            ifid_valid_d  = 1'b1;
            fetch_count_d = fetch_count_q + 16'd1;
          end
        end
      end
      StHalt: begin
        ifid_valid_d = 1'b0;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      ifid_inst_q   <= 16'h0000;
      ifid_pc_q     <= 8'h00;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifid_inst_q   <= ifid_inst_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc_out      = pc_q;
  assign ifid_inst   = ifid_inst_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_valid  = ifid_valid_q;
  assign halted      = (state_q == StHalt);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written reset/misalign sequences,
// and a randomized run compared against a behavioural fetch model.
module tb_fetch_unit;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pc_out;
  logic [15:0] inst_in;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halt;
  logic [15:0] ifid_inst;
  logic [7:0]  ifid_pc;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;
  logic        misalign;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_out      (pc_out),
    .inst_in     (inst_in),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .ifid_inst   (ifid_inst),
    .ifid_pc     (ifid_pc),
    .ifid_valid  (ifid_valid),
    .halted      (halted),
    .fetch_count (fetch_count),
    .misalign    (misalign)
  );

  // Combinational instruction memory: each address has a distinct word.
  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {~a, a ^ 8'h3C};
  endfunction

  assign inst_in = mem_word(pc_out);

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic rd, input logic [7:0] rpc, input logic hl);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = hl;
  endtask

  typedef struct {
    logic        st;
    logic        rd;
    logic [7:0]  rpc;
    logic        hl;
    logic [7:0]  e_pc;
    logic [7:0]  e_ipc;
    logic        e_v;
    logic        e_h;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic st, input logic rd, input logic [7:0] rpc, input logic hl,
                     input logic [7:0] e_pc, input logic [7:0] e_ipc, input logic e_v,
                     input logic e_h, input logic [15:0] e_cnt);
    vec_t v;
    v.st = st; v.rd = rd; v.rpc = rpc; v.hl = hl;
    v.e_pc = e_pc; v.e_ipc = e_ipc; v.e_v = e_v; v.e_h = e_h; v.e_cnt = e_cnt;
    vq.push_back(v);
  endtask

  // Behavioural model state
  logic [7:0]  m_pc, m_ipc;
  logic [15:0] m_inst, m_cnt;
  logic        m_v, m_h, m_mis;

  task automatic model_reset();
    m_pc = 8'h00; m_ipc = 8'h00; m_inst = 16'h0000; m_cnt = 16'h0000;
    m_v = 1'b0; m_h = 1'b0; m_mis = 1'b0;
  endtask

  task automatic model_step();
    if (m_h) begin
      m_v = 1'b0;
    end else if (halt) begin
      m_v = 1'b0;
      m_h = 1'b1;
    end else if (redirect) begin
      m_pc = (AlignEn && redirect_pc[0]) ? redirect_pc - 8'd1 : redirect_pc;
      if (AlignEn && redirect_pc[0]) m_mis = 1'b1;
      m_v = 1'b0;
    end else if (!stall) begin
      m_inst = mem_word(m_pc);
      m_ipc  = m_pc;
      m_v    = 1'b1;
      m_pc   = 8'((int'(m_pc) + 2) % 256);
      m_cnt  = m_cnt + 16'd1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"}, 32'(pc_out), 32'(m_pc));
    chk({tag, ".ifid_pc"}, 32'(ifid_pc), 32'(m_ipc));
    chk({tag, ".ifid_inst"}, 32'(ifid_inst), 32'(m_inst));
    chk({tag, ".valid"}, 32'(ifid_valid), 32'(m_v));
    chk({tag, ".halted"}, 32'(halted), 32'(m_h));
    chk({tag, ".count"}, 32'(fetch_count), 32'(m_cnt));
    chk({tag, ".misalign"}, 32'(misalign), 32'(m_mis));
  endtask

  // Called at posedge+1: async reset takes effect with no clock edge.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_pc;
    int         halt_cycles;

    drive(1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #12;
    model_reset();
    check_model("reset");
    rst_n = 1'b1;

    add(0, 0, 8'h00, 0, 8'h02, 8'h00, 1, 0, 16'd1);
    add(0, 0, 8'h00, 0, 8'h04, 8'h02, 1, 0, 16'd2);
    add(0, 0, 8'h00, 0, 8'h06, 8'h04, 1, 0, 16'd3);
    add(0, 0, 8'h00, 0, 8'h08, 8'h06, 1, 0, 16'd4);
    add(1, 0, 8'h00, 0, 8'h08, 8'h06, 1, 0, 16'd4);
    add(1, 0, 8'h00, 0, 8'h08, 8'h06, 1, 0, 16'd4);
    add(1, 0, 8'h00, 0, 8'h08, 8'h06, 1, 0, 16'd4);
    add(0, 0, 8'h00, 0, 8'h0A, 8'h08, 1, 0, 16'd5);
    add(1, 1, 8'h40, 0, 8'h40, 8'h08, 0, 0, 16'd5);
    add(0, 0, 8'h00, 0, 8'h42, 8'h40, 1, 0, 16'd6);
    add(0, 1, 8'hFC, 0, 8'hFC, 8'h40, 0, 0, 16'd6);
    add(0, 0, 8'h00, 0, 8'hFE, 8'hFC, 1, 0, 16'd7);
    add(0, 0, 8'h00, 0, 8'h00, 8'hFE, 1, 0, 16'd8);
    add(0, 0, 8'h00, 0, 8'h02, 8'h00, 1, 0, 16'd9);
    add(0, 1, 8'h20, 1, 8'h02, 8'h00, 0, 1, 16'd9);
    add(0, 0, 8'h00, 0, 8'h02, 8'h00, 0, 1, 16'd9);
    add(0, 1, 8'h30, 0, 8'h02, 8'h00, 0, 1, 16'd9);

    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].rd, vq[i].rpc, vq[i].hl);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.pc", i), 32'(pc_out), 32'(vq[i].e_pc));
      chk($sformatf("vec%0d.ifid_pc", i), 32'(ifid_pc), 32'(vq[i].e_ipc));
      chk($sformatf("vec%0d.ifid_inst", i), 32'(ifid_inst), 32'(mem_word(vq[i].e_ipc)));
      chk($sformatf("vec%0d.valid", i), 32'(ifid_valid), 32'(vq[i].e_v));
      chk($sformatf("vec%0d.halted", i), 32'(halted), 32'(vq[i].e_h));
      chk($sformatf("vec%0d.count", i), 32'(fetch_count), 32'(vq[i].e_cnt));
      chk($sformatf("vec%0d.misalign", i), 32'(misalign), 32'd0);
    end

    // Mid-operation reset out of HALT with nonzero PC and count
    drive(0, 0, 8'h00, 0);
    pulse_reset("midreset");

    // Odd redirect target
    exp_pc = AlignEn ? 8'h40 : 8'h41;
    drive(0, 1, 8'h41, 0);
    @(posedge clk);
    #1;
    chk("odd.pc", 32'(pc_out), 32'(exp_pc));
    chk("odd.valid", 32'(ifid_valid), 32'd0);
    chk("odd.misalign", 32'(misalign), 32'(AlignEn));
    drive(0, 0, 8'h00, 0);
    @(posedge clk);
    #1;
    chk("odd.next_ifid_pc", 32'(ifid_pc), 32'(exp_pc));
    chk("odd.next_valid", 32'(ifid_valid), 32'd1);
    chk("odd.sticky", 32'(misalign), 32'(AlignEn));
    drive(0, 1, 8'h10, 0);
    @(posedge clk);
    #1;
    chk("odd.sticky2", 32'(misalign), 32'(AlignEn));

    // Randomized run against the model
    pulse_reset("rand.reset");
    halt_cycles = 0;
    for (int n = 0; n < 600; n++) begin
      if (m_h && halt_cycles > 4) begin
        drive(0, 0, 8'h00, 0);
        pulse_reset("rand.reset");
        halt_cycles = 0;
      end
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), 8'($urandom),
            ($urandom_range(0, 60) == 0));
      @(posedge clk);
      model_step();
      #1;
      check_model("rand");
      if (m_h) halt_cycles++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the 16-bit core. Owns the 8-bit program counter, drives the byte address into the combinational instruction memory, and latches the returned 16-bit word into an IF/ID register for decode. Handles stall, taken-branch redirect with one-bubble flush, and a sticky halt.

## Interface
- `RESET_PC`, default 8'h00: PC value loaded on reset.
- `PC_STEP`, default 2: bytes per instruction; PC increment.
- `clk` in 1: core clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc_out` out 8: fetch address to instruction memory; equals internal PC register.
- `inst_in` in 16: instruction word from instruction memory for `pc_out`, valid same cycle (combinational memory).
- `stall` in 1: decode/hazard hold; freezes PC and IF/ID.
- `redirect` in 1: taken branch/jump from execute.
- `redirect_pc` in 8: target address, sampled when `redirect`=1.
- `halt` in 1: decode saw halt; fetch stops permanently until reset.
- `ifid_inst` out 16: latched instruction.
- `ifid_pc` out 8: address of `ifid_inst`.
- `ifid_valid` out 1: `ifid_inst` is a real instruction (0 = bubble).
- `halted` out 1: fetch is in HALT state.
- `fetch_count` out 16: number of instructions delivered with `ifid_valid`=1.
- `misalign` out 1: sticky odd-target flag (only with macro, else tied 0).

## Operation
- States: RUN, FLUSH, HALT. Reset enters RUN.
- RUN, no stall, no redirect: PC <= PC + PC_STEP; IF/ID <= {inst_in, PC}; `ifid_valid` <= 1; `fetch_count` += 1.
- RUN, stall=1, no redirect: PC, IF/ID, `ifid_valid`, `fetch_count` hold.
- redirect=1 (RUN or FLUSH, stall ignored): PC <= `redirect_pc`; `ifid_valid` <= 0; next state FLUSH.
- FLUSH: one cycle; behaves as RUN (fetches at new PC, delivers valid word unless stall/redirect); returns to RUN.
- halt=1 (any state except HALT, higher priority than redirect and stall): `ifid_valid` <= 0; PC holds; next state HALT.
- HALT: PC, IF/ID hold; `ifid_valid`=0; `halted`=1; only `rst_n` leaves.
- Priority: reset > halt > redirect > stall > normal advance.
- PC arithmetic is modulo 256: 8'hFE + 2 = 8'h00, no flag.
- `fetch_count` wraps 16'hFFFF -> 16'h0000.

## Timing
- Reset values: `pc_out`=RESET_PC, `ifid_inst`=16'h0000, `ifid_pc`=8'h00, `ifid_valid`=0, `halted`=0, `fetch_count`=0, `misalign`=0, state RUN.
- Reset is asynchronous mid-operation: all outputs go to reset values immediately, no partial update.
- Latency: instruction at address A appears on `ifid_inst` the cycle after `pc_out`=A with no stall.
- Redirect penalty: exactly one bubble (`ifid_valid`=0) after the redirect cycle; target instruction is valid two edges after `redirect` asserts.
- First valid instruction after reset release: first rising edge.
- Stall is level-sensitive; zero-cycle release.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined: on redirect with `redirect_pc[0]`=1, PC loads `{redirect_pc[7:1],1'b0}` and `misalign` sets (sticky until reset).
- Undefined: `redirect_pc` loaded unmodified; `misalign` tied 0.

## Test plan
- Reset release, no stall, memory returns word at pc -> `ifid_pc` sequence 00,02,04,06; `ifid_valid`=1 from first edge; `fetch_count`=4 after 4 edges.
- Stall high 3 cycles at PC=08 -> `pc_out` stays 08, `ifid_inst`/`fetch_count` unchanged; after release next `ifid_pc`=08.
- Redirect to 8'h40 while stall=1 -> next cycle `pc_out`=40, `ifid_valid`=0; following cycle `ifid_pc`=40, valid=1.
- Run from PC=FC -> `ifid_pc` FC, FE, 00; no flags.
- halt asserted together with redirect to 8'h20 -> `halted`=1, `ifid_valid`=0, `pc_out` unchanged thereafter; `rst_n` pulse returns `pc_out`=00.
- With `FETCH_ALIGN_CHECK_EN`: redirect to 8'h41 -> `pc_out`=40, `misalign`=1 and stays 1; without macro -> `pc_out`=41, `misalign`=0.
